// File: rtl/event_blinker_pkg.sv
// Shared types and width helpers for the event_blinker LED blink sequencer.
package event_blinker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    // Larger of two unsigned values.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to index 0..v-1, never less than one so degenerate
    // parameter choices still give a legal vector.
    function automatic int unsigned safe_clog2(input int unsigned v);
        return (v <= 32'd1) ? 32'd1 : $clog2(v);
    endfunction

endpackage

// File: rtl/event_blinker_timer.sv
// Loadable down-counter used to time the LED-on and LED-off phases.
// It stops at zero rather than wrapping; load has priority over enable.
module blink_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    input  logic         enable_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load, decrement toward zero, or hold.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (enable_i && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle event pulses into fixed-length LED blinks separated by
// a fixed dark gap; pulses arriving mid-blink are queued (saturating) and
// replayed back to back.
module event_blinker
    import event_blinker_pkg::*;
#(
    parameter int unsigned ON_CYCLES   = 32'd25_000_000,
    parameter int unsigned OFF_CYCLES  = 32'd12_500_000,
    parameter int unsigned MAX_PENDING = 32'd7,
    localparam int unsigned PW = $clog2(MAX_PENDING + 32'd1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pulse_i,
    input  logic          clear_i,
    output logic          led_o,
    output logic          busy_o,
    output logic [PW-1:0] pending_o,
    output logic          overflow_o
);

    localparam int unsigned TW = safe_clog2(max_u(ON_CYCLES, OFF_CYCLES));
    localparam logic [TW-1:0] ON_RELOAD  = TW'(ON_CYCLES - 32'd1);
    localparam logic [TW-1:0] OFF_RELOAD = TW'(OFF_CYCLES - 32'd1);
    localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PENDING);
    localparam logic [PW-1:0] PEND_ONE   = {{(PW-1){1'b0}}, 1'b1};

    blink_state_t  state_q, state_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic          led_q, led_d;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_value_s;
    logic          tmr_enable_s;
    logic          tmr_zero_s;

    blink_timer #(
        .W (TW)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (tmr_load_s),
        .load_value_i (tmr_value_s),
        .enable_i     (tmr_enable_s),
        .zero_o       (tmr_zero_s)
    );

    // Next state, queue depth, overflow flag and timer control.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        overflow_d   = overflow_q;
        tmr_load_s   = 1'b0;
        tmr_value_s  = {TW{1'b0}};
        tmr_enable_s = 1'b0;

        if (clear_i) begin
            // Abort: drop everything, force the timer back to zero.
            state_d     = IDLE;
            pending_d   = {PW{1'b0}};
            overflow_d  = 1'b0;
            tmr_load_s  = 1'b1;
            tmr_value_s = {TW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (pulse_i) begin
                        state_d     = ON;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = ON_RELOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ON: begin
                    if (pulse_i) begin
                        if (pending_q == PEND_MAX) begin
                            overflow_d = 1'b1;
                        end else begin
                            pending_d = pending_q + PEND_ONE;
                        end
                    end else begin
                        pending_d = pending_q;
                    end
                    if (tmr_zero_s) begin
                        state_d     = OFF;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = OFF_RELOAD;
                    end else begin
                        tmr_enable_s = 1'b1;
                    end
                end
                OFF: begin
                    if (tmr_zero_s) begin
                        // Exit edge: replay a queued blink, or consume a
                        // coincident pulse directly.
                        if (pending_q != {PW{1'b0}}) begin
                            state_d     = ON;
                            tmr_load_s  = 1'b1;
                            tmr_value_s = ON_RELOAD;
                            if (!pulse_i) begin
                                pending_d = pending_q - PEND_ONE;
                            end else begin
                                pending_d = pending_q;
                            end
                        end else if (pulse_i) begin
                            state_d     = ON;
                            tmr_load_s  = 1'b1;
                            tmr_value_s = ON_RELOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tmr_enable_s = 1'b1;
                        if (pulse_i) begin
                            if (pending_q == PEND_MAX) begin
                                overflow_d = 1'b1;
                            end else begin
                                pending_d = pending_q + PEND_ONE;
                            end
                        end else begin
                            pending_d = pending_q;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    pending_d  = {PW{1'b0}};
                    overflow_d = 1'b0;
                end
            endcase
        end

        led_d = (state_d == ON);
    end

    // FSM, queue, flag and LED registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pending_q  <= {PW{1'b0}};
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
        end
    end

    assign led_o      = led_q;
    assign busy_o     = (state_q != IDLE);
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_event_blinker.sv
// Scoreboard bench for event_blinker: a timeline-based reference model
// predicts the outputs after every edge, a monitor compares them.
module tb_event_blinker;

    localparam int ON   = 4;
    localparam int OFF  = 2;
    localparam int MAXP = 3;
    localparam int PW   = $clog2(MAXP + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pulse;
    logic          clear;
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;

    typedef struct packed {
        logic          led;
        logic          busy;
        logic [PW-1:0] pend;
        logic          ovf;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: a blink is described by the edge at which its LED
    // came on; everything else follows from elapsed edge counts.
    bit m_active;
    int m_start;
    int m_edge = 0;
    int m_pend;
    bit m_ovf;

    always #5 clk = ~clk;

    event_blinker #(
        .ON_CYCLES   (ON),
        .OFF_CYCLES  (OFF),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pulse_i    (pulse),
        .clear_i    (clear),
        .led_o      (led),
        .busy_o     (busy),
        .pending_o  (pend),
        .overflow_o (ovf)
    );

    function automatic void compare(input string name, input exp_t e);
        vectors++;
        if ({led, busy, pend, ovf} !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got led=%0b busy=%0b pending=%0d overflow=%0b, expected led=%0b busy=%0b pending=%0d overflow=%0b",
                     name, $time, led, busy, pend, ovf, e.led, e.busy, e.pend, e.ovf);
        end
    endfunction

    function automatic void model_reset();
        m_active = 1'b0;
        m_start  = 0;
        m_pend   = 0;
        m_ovf    = 1'b0;
    endfunction

    function automatic exp_t model_step(input bit p, input bit c);
        exp_t e;
        m_edge++;
        if (c) begin
            model_reset();
        end else if (!m_active) begin
            if (p) begin
                m_active = 1'b1;
                m_start  = m_edge;
            end
        end else if (m_edge - m_start == ON + OFF) begin
            if (m_pend > 0) begin
                m_start = m_edge;
                if (!p) m_pend--;
            end else if (p) begin
                m_start = m_edge;
            end else begin
                m_active = 1'b0;
            end
        end else if (p) begin
            if (m_pend == MAXP) m_ovf = 1'b1;
            else m_pend++;
        end
        e.led  = m_active && ((m_edge - m_start) < ON);
        e.busy = m_active;
        e.pend = PW'(m_pend);
        e.ovf  = m_ovf;
        return e;
    endfunction

    task automatic cyc(input bit p, input bit c);
        @(negedge clk);
        pulse = p;
        clear = c;
        sb_q.push_back(model_step(p, c));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    // Drop reset between edges, just after the edge the last cyc() prepared.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_reset", exp_t'(0));
        model_reset();
        @(negedge clk);
        pulse = 1'b0;
        clear = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: one expected entry per clock edge when stimulus was issued.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) compare("cycle", sb_q.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        pulse = 1'b1;
        clear = 1'b0;
        model_reset();
        #12;
        compare("reset_state", exp_t'(0));
        @(negedge clk);
        pulse = 1'b0;
        rst_n = 1'b1;

        // 1: single blink
        cyc(1'b1, 1'b0); idle(9);
        // 2: pulses at 0, 2, 3
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); idle(22);
        // 3: five pulses during the first blink -> saturate and overflow
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
        idle(30);
        // 4a: pulse on the OFF-exit edge with nothing queued
        cyc(1'b1, 1'b0); idle(5); cyc(1'b1, 1'b0); idle(10);
        // 4b: same with two queued
        cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); idle(3); cyc(1'b1, 1'b0); idle(25);
        // 5: clear during ON with pending 2, overflow set, coincident pulse
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
        idle(3); cyc(1'b1, 1'b1); idle(15);
        // 6: asynchronous reset in the middle of a blink
        cyc(1'b1, 1'b0); cyc(1'b0, 1'b0); async_reset(); idle(4);

        // Randomised traffic with occasional clears and resets
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(2) == 0, $urandom_range(59) == 0);
            if ($urandom_range(249) == 0) async_reset();
        end
        idle(2);
        @(posedge clk);
        #3;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
